// File: rtl/bus_timer.sv
// Programmable 32-bit down-counting timer on the word-addressed register bus.
// Optional capture input enabled by defining BUS_TIMER_CAPTURE_EN.
module bus_timer #(
    parameter logic [30:0] BASE_ADDR = 31'h0000_0100,
    parameter logic [31:0] ID_VALUE  = 32'h544D_5231
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [30:0] addr_bus,
    input  logic [31:0] data_bus_wr,
    output logic [31:0] data_bus_rd,
    input  logic        wr_strobe,
    input  logic        rd_strobe,
`ifdef BUS_TIMER_CAPTURE_EN
    input  logic        capture_in,
`endif
    output logic        irq
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_RELOAD   = 3'd2;
    localparam logic [2:0] OFF_COUNT    = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;
    localparam logic [2:0] OFF_ID       = 3'd5;
    localparam logic [2:0] OFF_CAPTURE  = 3'd6;

    logic        en;
    logic        auto_rl;
    logic        irqen;
    logic [15:0] prescale;
    logic [31:0] reload;
    logic [31:0] count;
    logic [15:0] pc;
    logic        exp_flag;
    logic        cap_flag;
    logic [31:0] capture_val;

    logic        in_window;
    logic [2:0]  offset;
    logic        wr_ctrl;
    logic        wr_prescale;
    logic        wr_reload;
    logic        wr_count;
    logic        wr_status;
    logic        tick;
    logic        expire;

    // No read side effects exist in this block.
    logic        unused_rd;
    assign unused_rd = rd_strobe;

    assign in_window   = (addr_bus[30:3] == BASE_ADDR[30:3]);
    assign offset      = addr_bus[2:0];
    assign wr_ctrl     = wr_strobe && in_window && (offset == OFF_CTRL);
    assign wr_prescale = wr_strobe && in_window && (offset == OFF_PRESCALE);
    assign wr_reload   = wr_strobe && in_window && (offset == OFF_RELOAD);
    assign wr_count    = wr_strobe && in_window && (offset == OFF_COUNT);
    assign wr_status   = wr_strobe && in_window && (offset == OFF_STATUS);

    assign tick   = en && (pc == prescale);
    assign expire = tick && (count == '0);

    // A bus write to CTRL overrides the one-shot EN clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en      <= 1'b0;
            auto_rl <= 1'b0;
            irqen   <= 1'b0;
        end else if (wr_ctrl) begin
            en      <= data_bus_wr[0];
            auto_rl <= data_bus_wr[1];
            irqen   <= data_bus_wr[2];
        end else if (expire && !auto_rl) begin
            en      <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale <= '0;
            reload   <= '0;
        end else begin
            if (wr_prescale)
                prescale <= data_bus_wr[15:0];
            if (wr_reload)
                reload <= data_bus_wr;
        end
    end

    // pc restarts only when EN changes via CTRL; a smaller new P makes pc wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
        end else if (wr_ctrl && (!data_bus_wr[0] || !en)) begin
            pc <= '0;
        end else if (en) begin
            pc <= tick ? 16'd0 : pc + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (wr_count) begin
            count <= data_bus_wr;
        end else if (tick) begin
            if (count != '0)
                count <= count - 32'd1;
            else if (auto_rl)
                count <= reload;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_flag <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (expire)
                exp_flag <= 1'b1;
            else if (wr_status && data_bus_wr[0])
                exp_flag <= 1'b0;
            irq <= exp_flag && irqen;
        end
    end

`ifdef BUS_TIMER_CAPTURE_EN
    logic sync1;
    logic sync2;
    logic sync3;
    logic cap_p1;
    logic cap_p2;

    // Edge on sync2 -> two pipeline stages -> capture: three cycles total.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            sync3       <= 1'b0;
            cap_p1      <= 1'b0;
            cap_p2      <= 1'b0;
            capture_val <= '0;
            cap_flag    <= 1'b0;
        end else begin
            sync1  <= capture_in;
            sync2  <= sync1;
            sync3  <= sync2;
            cap_p1 <= sync2 && !sync3;
            cap_p2 <= cap_p1;
            if (cap_p2) begin
                capture_val <= count;
                cap_flag    <= 1'b1;
            end else if (wr_status && data_bus_wr[2]) begin
                cap_flag    <= 1'b0;
            end
        end
    end
`else
    assign capture_val = '0;
    assign cap_flag    = 1'b0;
`endif

    always_comb begin
        data_bus_rd = '0;
        if (in_window) begin
            case (offset)
                OFF_CTRL:     data_bus_rd = {29'd0, irqen, auto_rl, en};
                OFF_PRESCALE: data_bus_rd = {16'd0, prescale};
                OFF_RELOAD:   data_bus_rd = reload;
                OFF_COUNT:    data_bus_rd = count;
                OFF_STATUS:   data_bus_rd = {29'd0, cap_flag, en, exp_flag};
                OFF_ID:       data_bus_rd = ID_VALUE;
                OFF_CAPTURE:  data_bus_rd = capture_val;
                default:      data_bus_rd = '0;
            endcase
        end
    end

endmodule
